// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a byte FIFO and a level interrupt.
// Register window at BASE_ADDR: +0x0 RXDATA (pop on read), +0x4 STATUS (bits 2-4 W1C), +0x8 CTRL.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h2000_0100,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        rx_valid,
  input  logic        rx,
  output logic        rx_interrupt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  function automatic logic f_even_par(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Synchroniser, edge detector and FSM state
  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  // Register file and FIFO
  logic [1:0]    r_ctrl;
  logic          r_overrun, r_frame_err;
  logic          r_irq;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;

  logic [31:0]   w_offset;
  logic          w_in_win, w_status_wr, w_ctrl_wr, w_pop_req, w_pop;
  logic          w_empty, w_full, w_stop_smp, w_push, w_push_ok, w_overrun_set, w_frame_set;
  logic          w_par_err;
  logic [31:0]   w_status;
  logic          w_unused_ok;

  // ------------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------------
  assign w_offset    = addr - BASE_ADDR;
  assign w_in_win    = (w_offset < 32'd12);
  assign w_status_wr = write_enable && w_in_win && (addr[3:2] == 2'b01);
  assign w_ctrl_wr   = write_enable && w_in_win && (addr[3:2] == 2'b10);
  assign w_pop_req   = read_enable && w_in_win && (addr[3:2] == 2'b00);
  assign rx_valid    = read_enable && w_in_win;

  // ------------------------------------------------------------------------
  // FIFO flags and push/pop arbitration
  // ------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = w_pop_req && !w_empty;

  // The stop-bit sample cycle is the push cycle, so the push strobe is decoded from the FSM state.
  assign w_stop_smp  = (r_state == ST_STOP) && (r_cnt == C_LAST);
`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err, w_par_set;
  assign w_par_set = (r_state == ST_PARITY) && (r_cnt == C_LAST) &&
                     (f_even_par(r_shift) != r_rx_sync);
  assign w_push    = w_stop_smp && r_rx_sync && !r_par_bad;
  assign w_par_err = r_parity_err;
`else
  assign w_push    = w_stop_smp && r_rx_sync;
  assign w_par_err = 1'b0;
`endif
  assign w_frame_set   = w_stop_smp && !r_rx_sync;
  // A pop in the same cycle frees the slot, so a push while full only overruns without a pop.
  assign w_push_ok     = w_push && (!w_full || w_pop);
  assign w_overrun_set = w_push && w_full && !w_pop;

  assign w_status = {27'd0, w_par_err, r_frame_err, r_overrun, w_full, !w_empty};

  // Upper write-data bits have no storage behind them.
  assign w_unused_ok = &{1'b0, write_data};

  // 2-flop synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receive FSM: start-bit qualification, mid-bit data sampling, stop-bit check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= 3'd0;
`ifdef UART_RX_PARITY_EN
          r_par_bad <= 1'b0;
`endif
          // A low line after a frame error produces no falling edge until it has gone high again.
          if (r_ctrl[0] && r_rx_prev && !r_rx_sync) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_state <= r_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == C_LAST) begin
            r_cnt     <= '0;
            r_par_bad <= w_par_set;
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage (contents are meaningless while the pointers say empty)
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
  end

  // FIFO pointers, one extra bit to tell full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Sticky error flags: a hardware set in the same cycle beats a software clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (w_status_wr && write_data[2]) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (w_status_wr && write_data[3]) begin
        r_frame_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag, same set-over-clear priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_err <= 1'b0;
    end else if (w_par_set) begin
      r_parity_err <= 1'b1;
    end else if (w_status_wr && write_data[4]) begin
      r_parity_err <= 1'b0;
    end
  end
`endif

  // Control register and registered interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= 2'b00;
      r_irq  <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_ctrl <= write_data[1:0];
      end
      r_irq <= r_ctrl[1] && (!w_empty || r_overrun);
    end
  end

  assign rx_interrupt = r_irq;

  // Combinational read mux keyed on the word offset
  always_comb begin
    read_data = 32'd0;
    case (addr[3:2])
      2'b00: begin
        if (w_empty) begin
          read_data = 32'd0;
        end else begin
          read_data = {24'd0, r_mem[r_rd_ptr[AW-1:0]]};
        end
      end
      2'b01:   read_data = w_status;
      2'b10:   read_data = {30'd0, r_ctrl};
      default: read_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based model of the register map is compared against the DUT every cycle.
module tb_uart_rx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h2000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, write_data;
  logic        write_enable, read_enable;
  logic [31:0] read_data;
  logic        rx_valid;
  logic        rx;
  logic        rx_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [7:0]  m_q[$];
  logic        m_over, m_frame, m_par;
  logic [1:0]  m_ctrl;
  logic        m_irq_exp;
  logic        quiet;
  logic [31:0] last_rd;
  logic [31:0] a_off;

  uart_rx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data),
    .rx_valid(rx_valid), .rx(rx), .rx_interrupt(rx_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_par, m_frame, m_over, (m_q.size() == DEPTH), (m_q.size() != 0)};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'b00:   return (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
      2'b01:   return m_status();
      2'b10:   return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
    m_ctrl = 2'b00; m_irq_exp = 1'b0;
  endtask

  // Compare DUT against model, then apply the bus action the next edge will capture
  always @(negedge clk) begin
    if (rst_n) begin
      a_off = addr - BASE;
      if (!(a_off >= 32'd12 && a_off < 32'd16))
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, read_enable && (a_off < 32'd12)});
      if (quiet) begin
        if (a_off < 32'd16) chk("read_data", read_data, m_read(addr));
        chk("rx_interrupt", {31'd0, rx_interrupt}, {31'd0, m_irq_exp});
        m_irq_exp = m_ctrl[1] && ((m_q.size() != 0) || m_over);
        if (read_enable && a_off < 32'd12 && addr[3:2] == 2'b00 && m_q.size() != 0)
          void'(m_q.pop_front());
        if (write_enable && a_off < 32'd12 && addr[3:2] == 2'b01) begin
          if (write_data[2]) m_over  = 1'b0;
          if (write_data[3]) m_frame = 1'b0;
          if (write_data[4]) m_par   = 1'b0;
        end
        if (write_enable && a_off < 32'd12 && addr[3:2] == 2'b10)
          m_ctrl = write_data[1:0];
      end
    end
    last_rd = read_data;
  end

  task automatic bus_rd(input logic [31:0] a);
    @(posedge clk); #2;
    addr = a; read_enable = 1'b1;
    @(posedge clk); #2;
    read_enable = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    addr = a; write_data = d; write_enable = 1'b1;
    @(posedge clk); #2;
    write_enable = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk); #2;
    rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  // Send one frame; stop_ok=0 drives a low stop bit, par_flip=1 sends the wrong parity bit
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_flip);
    logic en;
    logic par_bad;
    en = m_ctrl[0];
    quiet = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
    par_bad = par_flip;
`else
    par_bad = 1'b0;
`endif
    drive_bit(stop_ok);
    @(posedge clk); #2;
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    if (en) begin
      if (par_bad) m_par = 1'b1;
      if (!stop_ok) m_frame = 1'b1;
      else if (!par_bad) begin
        if (m_q.size() == DEPTH) m_over = 1'b1;
        else m_q.push_back(b);
      end
    end
    m_irq_exp = m_ctrl[1] && ((m_q.size() != 0) || m_over);
    quiet = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rx = 1'b1; addr = BASE + 32'h4; write_data = 32'd0;
    write_enable = 1'b0; read_enable = 1'b0; quiet = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_irq", {31'd0, rx_interrupt}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    quiet = 1'b1;

    // 1: basic receive of 0xA5
    bus_wr(BASE + 32'h8, 32'h1);
    send_frame(8'hA5, 1'b1, 1'b0);
    bus_rd(BASE + 32'h4); chk("t1_status_pending", last_rd, 32'h1);
    bus_rd(BASE);         chk("t1_rxdata", last_rd, 32'hA5);
    bus_rd(BASE + 32'h4); chk("t1_status_after", last_rd, 32'h0);
    bus_rd(BASE + 32'hC); chk("t1_unmapped", last_rd, 32'h0);

    // 2: overflow with five bytes, W1C overrun, drain in order
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    bus_rd(BASE + 32'h4); chk("t2_status_full_ovr", last_rd, 32'h7);
    bus_rd(BASE + 32'h100);
    bus_rd(BASE + 32'h4); chk("t2_no_pop_outside", last_rd, 32'h7);
    bus_wr(BASE + 32'h4, 32'h4);
    bus_rd(BASE + 32'h4); chk("t2_overrun_cleared", last_rd, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(BASE); chk("t2_drain", last_rd, 32'(i));
    end
    bus_rd(BASE);         chk("t2_empty_read", last_rd, 32'h0);
    bus_rd(BASE + 32'h4); chk("t2_status_empty", last_rd, 32'h0);

    // 3: frame error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    bus_rd(BASE + 32'h4); chk("t3_frame_err", last_rd, 32'h8);
    send_frame(8'h7E, 1'b1, 1'b0);
    bus_rd(BASE);         chk("t3_rx_after_err", last_rd, 32'h7E);
    bus_wr(BASE + 32'h4, 32'h18);
    bus_rd(BASE + 32'h4); chk("t3_frame_cleared", last_rd, 32'h0);

    // 4: one-clock glitch while idle; then a frame with rx_en off
    quiet = 1'b0;
    @(posedge clk); #2; rx = 1'b0;
    @(posedge clk); #2; rx = 1'b1;
    repeat (12) @(posedge clk);
    #2; quiet = 1'b1;
    bus_rd(BASE + 32'h4); chk("t4_glitch_status", last_rd, 32'h0);
    bus_wr(BASE + 32'h8, 32'h0);
    send_frame(8'h55, 1'b1, 1'b0);
    bus_rd(BASE + 32'h4); chk("t4_disabled_status", last_rd, 32'h0);

    // 5: interrupt, pop clears it a cycle later, reset mid-byte
    bus_wr(BASE + 32'h8, 32'h3);
    send_frame(8'h11, 1'b1, 1'b0);
    chk("t5_irq_set", {31'd0, rx_interrupt}, 32'h1);
    bus_rd(BASE); chk("t5_rxdata", last_rd, 32'h11);
    chk("t5_irq_lags", {31'd0, rx_interrupt}, 32'h1);
    @(posedge clk); #1;
    chk("t5_irq_clear", {31'd0, rx_interrupt}, 32'h0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("t5_irq_before_rst", {31'd0, rx_interrupt}, 32'h1);
    quiet = 1'b0;
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    #1; rst_n = 1'b0;
    #1;
    chk("t5_irq_rst", {31'd0, rx_interrupt}, 32'h0);
    chk("t5_read_data_rst", read_data, 32'h0);
    model_reset();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1; quiet = 1'b1;
    bus_rd(BASE + 32'h8); chk("t5_ctrl_after_rst", last_rd, 32'h0);
    bus_wr(BASE + 32'h8, 32'h1);
    send_frame(8'h5A, 1'b1, 1'b0);
    bus_rd(BASE);         chk("t5_rx_after_rst", last_rd, 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 6: parity error discards, good parity pushes
    send_frame(8'h03, 1'b1, 1'b1);
    bus_rd(BASE + 32'h4); chk("t6_parity_err", last_rd, 32'h10);
    send_frame(8'h03, 1'b1, 1'b0);
    bus_rd(BASE);         chk("t6_parity_ok", last_rd, 32'h03);
`else
    // 6: without parity support STATUS bit4 stays 0
    bus_wr(BASE + 32'h4, 32'h10);
    bus_rd(BASE + 32'h4); chk("t6_bit4_zero", last_rd, 32'h0);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
